// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single data-memory port: CPU (port 0) has priority, the loader
// (port 1) is aged so it cannot starve. Issue, access and response are each one register stage.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              cpu_stall,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_xfer_size,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

  logic [3:0]        r_wait_cnt;
  logic              r_mem_we;
  logic              r_mem_re;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_owner;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic w_wait_max;
  logic w_gnt0;
  logic w_gnt1;
  logic w_stall;
  logic w_we;

  // Port 1 wins a contested cycle only once it has aged to WaitMax.
  assign w_wait_max = (r_wait_cnt == WaitMax);
  assign w_gnt0     = ~reset & req0 & ~(req1 & w_wait_max);
  assign w_gnt1     = ~reset & req1 & (~req0 | w_wait_max);
  assign w_stall    = req0 & ~w_gnt0;
  assign w_we       = w_gnt1 ? we1 : we0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt     <= '0;
      r_mem_we       <= 1'b0;
      r_mem_re       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_owner        <= 1'b0;
      r_rdata        <= '0;
      r_rvalid0      <= 1'b0;
      r_rvalid1      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (req1 && !w_gnt1) begin
        r_wait_cnt <= w_wait_max ? r_wait_cnt : r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_gnt0 || w_gnt1) begin
        r_mem_addr  <= w_gnt1 ? addr1 : addr0;
        r_mem_wdata <= w_gnt1 ? wdata1 : wdata0;
        r_mem_we    <= w_we;
        r_mem_re    <= ~w_we;
        r_owner     <= w_gnt1;
      end else begin
        r_mem_we <= 1'b0;
        r_mem_re <= 1'b0;
      end

      // Read data is captured in the access cycle; the owner tag rides along one stage.
      if (r_mem_re) begin
        r_rdata <= mem_rdata;
      end
      r_rvalid0 <= r_mem_re & ~r_owner;
      r_rvalid1 <= r_mem_re & r_owner;

      if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign gnt0          = w_gnt0;
  assign gnt1          = w_gnt1;
  assign cpu_stall     = w_stall;
  assign mem_we        = r_mem_we;
  assign mem_re        = r_mem_re;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_xfer_size = 4'd8;
  assign rdata         = r_rdata;
  assign rvalid0       = r_rvalid0;
  assign rvalid1       = r_rvalid1;
  assign stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference arbitration model predicts grants, and expected
// read responses are queued at grant time with their due cycle.
module tb_dmem_arbiter;

  localparam int unsigned MaxWait = 4;
  localparam int unsigned CntW    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [63:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, cpu_stall;
  logic        mem_we, mem_re;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic [3:0]  mem_xfer_size;
  logic        rvalid0, rvalid1;
  logic [CntW-1:0] stall_cycles;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .MAX_WAIT(MaxWait),
    .CNT_W   (CntW)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .req1         (req1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .cpu_stall    (cpu_stall),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_xfer_size(mem_xfer_size),
    .mem_rdata    (mem_rdata),
    .rdata        (rdata),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .stall_cycles (stall_cycles)
  );

  function automatic logic [63:0] init_val(input int i);
    if (i == 16) return 64'hDEAD_BEEF;
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  // Data memory: combinational read, write at posedge, reloaded during reset.
  logic [63:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  typedef struct {
    int          due;
    bit          port;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  logic [63:0] sh [256];
  int          cyc;
  int          m_wait;
  int          m_stall;
  int          n_checks;
  int          n_errs;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("rvalid0", rvalid0, !e.port);
      check("rvalid1", rvalid1, e.port);
      check("rdata", rdata, e.data);
    end else begin
      check("rvalid0_idle", rvalid0, 0);
      check("rvalid1_idle", rvalid1, 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    #2;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    @(posedge clk);
    #1;
    cyc++;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("xfer_size", mem_xfer_size, 8);
    q.delete();
    m_wait  = 0;
    m_stall = 0;
    for (int i = 0; i < 256; i++) sh[i] = init_val(i);
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
  endtask

  task automatic step(input bit r0, input bit w0, input logic [63:0] a0, input logic [63:0] d0,
                      input bit r1, input bit w1, input logic [63:0] a1, input logic [63:0] d1);
    bit          g0, g1, ew, er;
    logic [63:0] ea, ed;
    exp_t        e;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #2;
    g0 = r0 && !(r1 && m_wait == MaxWait);
    g1 = r1 && (!r0 || m_wait == MaxWait);
    check("gnt0", gnt0, g0);
    check("gnt1", gnt1, g1);
    check("cpu_stall", cpu_stall, r0 && !g0);
    if (r0 && !g0 && m_stall < (1 << CntW) - 1) m_stall++;
    m_wait = (r1 && !g1) ? m_wait + 1 : 0;
    ew = (g0 && w0) || (g1 && w1);
    er = (g0 && !w0) || (g1 && !w1);
    ea = g1 ? a1 : a0;
    ed = g1 ? d1 : d0;
    if (er) begin
      e.due  = cyc + 2;
      e.port = g1;
      e.data = sh[ea[7:0]];
      q.push_back(e);
    end
    if (ew) sh[ea[7:0]] = ed;
    @(posedge clk);
    #1;
    cyc++;
    check("mem_we", mem_we, ew);
    check("mem_re", mem_re, er);
    if (g0 || g1) check("mem_addr", mem_addr, ea);
    if (ew) check("mem_wdata", mem_wdata, ed);
    check("stall_cycles", stall_cycles, m_stall);
    check_resp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_errs = 0;
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    do_reset();

    // Single CPU read of the preloaded word.
    step(1, 0, 64'h10, 0, 0, 0, 0, 0);
    idle(3);

    // CPU write then immediate read of the same address.
    step(1, 1, 64'h20, 64'h55, 0, 0, 0, 0);
    step(1, 0, 64'h20, 0, 0, 0, 0, 0);
    idle(3);

    // Loader write followed by CPU read of that address.
    step(0, 0, 0, 0, 1, 1, 64'h70, 64'h1234_5678_9ABC_DEF0);
    step(1, 0, 64'h70, 0, 0, 0, 0, 0);
    idle(3);

    // Contention: aging hands port 1 every fifth cycle.
    for (int i = 0; i < 12; i++) step(1, 0, 64'h30, 0, 1, 0, 64'h40, 0);
    idle(3);

    // Alternating owners, back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 0, 64'h50 + 64'(i), 0, 0, 0, 0, 0);
      else            step(0, 0, 0, 0, 1, 0, 64'h60 + 64'(i), 0);
    end
    idle(3);

    // Reset right after a loader read grant drops the response.
    step(0, 0, 0, 0, 1, 0, 64'h12, 0);
    do_reset();
    idle(3);

    // Long contention to saturate the stall counter.
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 64'(i % 8), 0, 1, 0, 64'h80 + 64'(i % 8), 0);
    end
    idle(3);
    check("stall_sat", stall_cycles, (1 << CntW) - 1);
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters.
- Port 0 is the CPU MEM stage and is the priority requester. Port 1 is the program/debug loader.
- Registers the winning request onto the datamem control/address/data lines, and routes the returned read data back to its owner with a one-cycle valid pulse.
- Generates the pipeline stall for the CPU and keeps port 1 from starving through an aging counter.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MAX_WAIT, 4, consecutive denied cycles after which port 1 takes priority (range 1..15).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  CPU request; held until gnt0.
- we0  in  1  CPU request type: 1 = write, 0 = read.
- addr0  in  ADDR_W  CPU address.
- wdata0  in  DATA_W  CPU write data.
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  loader request; same meaning as port 0.
- gnt0, gnt1  out  1  combinational grant, same cycle as req.
- cpu_stall  out  1  req0 & ~gnt0.
- mem_we, mem_re  out  1  registered datamem write/read enables.
- mem_addr  out  ADDR_W  registered datamem address.
- mem_wdata  out  DATA_W  registered datamem write data.
- mem_xfer_size  out  4  constant 4'd8.
- mem_rdata  in  DATA_W  datamem read data, combinational from mem_addr.
- rdata  out  DATA_W  registered read data to requesters.
- rvalid0, rvalid1  out  1  one-cycle read-response pulse for the owner.
- stall_cycles  out  CNT_W  saturating count of cycles with cpu_stall=1.

Behaviour:
- Reset: all outputs and state go to 0 (mem_we, mem_re, mem_addr, mem_wdata, rdata, rvalid0/1, stall_cycles, wait counter, pipeline owner tags).
  - Exception: mem_xfer_size is constant 8.
  - gnt0/gnt1 are combinational and are forced to 0 while reset=1.
  - Reset asserted mid-transfer drops any in-flight access: no rvalid pulse, and no memory write for a request that has not yet reached mem_we.
- Arbitration, cycle N, combinational:
  - Only req0: gnt0=1.
  - Only req1: gnt1=1.
  - Both requesting and wait_cnt < MAX_WAIT: gnt0=1.
  - Both requesting and wait_cnt == MAX_WAIT: gnt1=1.
  - At most one grant is asserted per cycle.
- Wait counter:
  - Increments on cycles with req1 & ~gnt1.
  - Clears on gnt1 or ~req1.
  - Never exceeds MAX_WAIT.
- Issue stage, posedge ending cycle N:
  - If a grant was given: mem_addr/mem_wdata take the granted port's values; mem_we = we; mem_re = ~we; the owner tag is captured.
  - If no grant: mem_we = mem_re = 0, and mem_addr/mem_wdata hold their previous values.
- Access, cycle N+1:
  - datamem sees the registered controls. A write commits at the posedge ending N+1.
  - If mem_re=1, rdata is captured from mem_rdata at that same edge.
- Response, cycle N+2:
  - rvalid for the owner is high for exactly one cycle; rdata is held until the next read capture.
  - Writes produce no rvalid.
- Latency and throughput:
  - Grant to rvalid is 2 cycles.
  - The block is fully pipelined: back-to-back grants every cycle are allowed, including alternating owners.
- Read-after-write hazard: a write granted in N followed by a read of the same address granted in N+1 returns the new data (write commits before the read's access cycle).
- Requester handshake: requesters hold req/we/addr/wdata stable until their grant. The arbiter does not latch ungranted requests.
- stall_cycles:
  - Increments on each cycle with cpu_stall=1.
  - Saturates at all-ones.
  - Clears only on reset.

Test Plan:
- Reset, then a single req0 read of addr 0x10 (memory preloaded with 0xDEADBEEF) -> gnt0 in the same cycle; mem_re=1, mem_addr=0x10 in N+1; rvalid0=1, rdata=0xDEADBEEF in N+2 for one cycle; rvalid1 stays 0.
- req0 write 0x55 to 0x20 in cycle N, then req0 read of 0x20 in N+1 -> mem_we=1 in N+1 only; read returns 0x55 with rvalid0 in N+3.
- req0 and req1 held high continuously with MAX_WAIT=4 -> gnt0 for 4 cycles, gnt1 on the 5th, then the pattern repeats; cpu_stall=1 on each gnt1 cycle; stall_cycles=1 after the first period.
- Both ports issue reads of different addresses on alternating cycles -> rvalid0/rvalid1 alternate with the correct rdata each; no cycle has both rvalid pulses.
- Reset asserted in the cycle after a gnt1 read -> no rvalid1; all outputs are 0 on the next cycle; wait_cnt and stall_cycles are 0.
- Force cpu_stall high for 2^CNT_W+3 cycles (CNT_W=4 build) -> stall_cycles saturates at 15 and holds.
